seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised Moore serial-pattern detector. Successor to the fixed 4-bit "1001" detector.
- Adds: programmable pattern width and value, runtime pattern reload, selectable overlap mode, input-valid qualification, and a saturating match counter.
- Sits on a 1-bit serial data path. Raises a registered match flag and keeps a running count for status readout.

Parameters:
- PAT_W, 4, pattern length in bits (2..16).
- PAT_INIT, 4'b1001, pattern loaded at reset. Bit PAT_W-1 is the first bit expected on the line.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = restart after each full match.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- din_valid  input  1  din is sampled only on edges where this is 1.
- din  input  1  serial data bit.
- pat_load  input  1  load pat_in as the new pattern.
- pat_in  input  PAT_W  new pattern value, MSB = first bit.
- cnt_clr  input  1  synchronous clear of match_cnt.
- dout  output  1  Moore match flag: 1 while the FSM is in MATCH.
- match_cnt  output  CNT_W  saturating count of full matches.
- busy  output  1  1 when state is not IDLE.

Behaviour:
- Reset:
  - rst low forces, immediately and asynchronously: state = IDLE, pattern = PAT_INIT, history cleared, received count = 0, dout = 0, match_cnt = 0, busy = 0.
  - Reset has priority over every other input and aborts any partial match.
- States: IDLE, TRACK(k) for k = 0..PAT_W-1 matched bits, MATCH (k = PAT_W). Encoding is free.
- IDLE:
  - The first edge after reset release moves IDLE -> TRACK(0) unconditionally.
  - din and din_valid are ignored on that edge.
- Sampling:
  - On an edge with din_valid = 1 in TRACK or MATCH, din is shifted into the history.
  - New k = the largest j <= min(received, PAT_W) such that the last j received bits equal pattern bits [PAT_W-1 : PAT_W-j].
  - k = PAT_W selects MATCH.
- din_valid = 0: state, history, dout and match_cnt all hold.
- Overlap mode:
  - OVERLAP = 1: after MATCH, the next k is computed over the full history. MATCH -> MATCH is possible (e.g. pattern 1111).
  - OVERLAP = 0: entering MATCH clears the history and received count. The next sampled bit is evaluated alone, so k is 0 or 1.
- dout:
  - Registered, driven from the state only (Moore).
  - If the last pattern bit is sampled at edge N, dout = 1 from edge N until the next edge that samples a bit and leaves MATCH.
  - Because of the hold rule, a gap in din_valid stretches dout.
- match_cnt:
  - Increments by 1 on every sampled edge whose next state is MATCH, including MATCH -> MATCH.
  - Saturates at 2^CNT_W - 1; no wrap.
  - cnt_clr = 1 sets it to 0 on that edge. cnt_clr wins over a simultaneous increment.
- pat_load:
  - On an edge with pat_load = 1, the pattern register takes pat_in. History and received count clear, state goes to TRACK(0), dout goes to 0.
  - pat_load has priority over din_valid on the same edge; that din is discarded.
  - match_cnt is unaffected.
  - pat_load while in IDLE loads the pattern and moves to TRACK(0).
- busy = 1 in every state except IDLE.

Test Plan:
- Reset, idle and basic match: rst low, then release; first edge -> busy = 1, state TRACK(0). Feed 1,0,0,1 (valid each cycle) -> dout = 1 the cycle after the 4th bit, match_cnt = 1.
- Overlap on: stream 1,0,0,1,0,0,1 -> dout high after bits 4 and 7, match_cnt = 2.
- Overlap off: the same stream -> only bit 4 matches, match_cnt = 1.
- Self-overlap and saturation: pat_load 4'b1111 with OVERLAP = 1 and CNT_W = 2. Feed seven 1s -> matches at bits 4, 5, 6 and 7, and match_cnt saturates at 3.
- Valid gaps and pattern reload:
  - 1,0,[valid low 3 cycles],0,1 -> a single match. dout stays high while valid is low after the match.
  - pat_load 4'b0110 mid-stream after 1,0,0 -> dout = 0, next 0,1,1,0 -> match.
- Asynchronous reset mid-match: in MATCH, pull rst low between edges -> dout, busy and match_cnt drop to 0 immediately without a clock, and the pattern returns to 1001.

Source files
------------

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial-pattern detector with runtime pattern
// reload, overlap mode, din qualification and a saturating match count.
module seq_detector_param #(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = 4'b1001,
  parameter int               OVERLAP  = 1,
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
);

  localparam int KW = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    MATCH
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [KW-1:0]      rcv_q, rcv_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_W-1:0]   hist_sh;
  logic [KW-1:0]      rcv_sh;
  logic [KW-1:0]      k_new;
  logic [PAT_W-1:0]   pfx;
  logic               ok;

  // k_new: longest suffix of the shifted history equal to a pattern prefix
  always_comb begin
    hist_sh = {hist_q[PAT_W-2:0], din};
    rcv_sh  = (rcv_q == KW'(PAT_W)) ? rcv_q : rcv_q + KW'(1);
    k_new   = '0;
    pfx     = '0;
    ok      = 1'b0;
    for (int j = 1; j <= PAT_W; j++) begin
      pfx = pat_q >> (PAT_W - j);
      ok  = (j <= int'(rcv_sh));
      for (int i = 0; i < PAT_W; i++) begin
        if (i < j && hist_sh[i] != pfx[i]) begin
          ok = 1'b0;
        end
      end
      if (ok) begin
        k_new = KW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    rcv_d   = rcv_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        state_d = TRACK;
        if (pat_load) begin
          pat_d = pat_in;
        end
      end
      TRACK, MATCH: begin
        if (pat_load) begin
          pat_d   = pat_in;
          hist_d  = '0;
          rcv_d   = '0;
          state_d = TRACK;
        end else if (din_valid) begin
          hist_d  = hist_sh;
          rcv_d   = rcv_sh;
          state_d = TRACK;
          if (k_new == KW'(PAT_W)) begin
            state_d = MATCH;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            // non-overlap: next bit is judged on its own
            if (OVERLAP == 0) begin
              hist_d = '0;
              rcv_d  = '0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= PAT_INIT;
      hist_q  <= '0;
      rcv_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      rcv_q   <= rcv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout      = (state_q == MATCH);
  assign busy      = (state_q != IDLE);
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three variants (overlap, no overlap,
// 2-bit counter) driven together and compared to a suffix/prefix model.
module tb_seq_detector_param;

  localparam int PW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       v   = 1'b0;
  logic       d   = 1'b0;
  logic       pl  = 1'b0;
  logic [3:0] pi  = 4'b0;
  logic       cc  = 1'b0;

  logic       dout0, dout1, dout2;
  logic       busy0, busy1, busy2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  logic       dout_a [3];
  logic       busy_a [3];
  logic [7:0] cnt_a  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detector_param dut0 (
    .clk(clk), .rst(rst), .din_valid(v), .din(d),
    .pat_load(pl), .pat_in(pi), .cnt_clr(cc),
    .dout(dout0), .match_cnt(cnt0), .busy(busy0)
  );

  seq_detector_param #(.OVERLAP(0)) dut1 (
    .clk(clk), .rst(rst), .din_valid(v), .din(d),
    .pat_load(pl), .pat_in(pi), .cnt_clr(cc),
    .dout(dout1), .match_cnt(cnt1), .busy(busy1)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din_valid(v), .din(d),
    .pat_load(pl), .pat_in(pi), .cnt_clr(cc),
    .dout(dout2), .match_cnt(cnt2), .busy(busy2)
  );

  assign dout_a[0] = dout0;
  assign dout_a[1] = dout1;
  assign dout_a[2] = dout2;
  assign busy_a[0] = busy0;
  assign busy_a[1] = busy1;
  assign busy_a[2] = busy2;
  assign cnt_a[0]  = cnt0;
  assign cnt_a[1]  = cnt1;
  assign cnt_a[2]  = {6'b0, cnt2};

  // reference model: recent bits as an integer, matched arithmetically
  bit midle [3];
  int mh    [3];
  int mn    [3];
  int mk    [3];
  int mc    [3];
  int mpat  [3];

  function automatic bit ov(int u);
    return u != 1;
  endfunction

  function automatic int cmax(int u);
    return (u == 2) ? 3 : 255;
  endfunction

  function automatic int calc_k(int u);
    int lim;
    lim = (mn[u] < PW) ? mn[u] : PW;
    for (int j = lim; j >= 1; j--) begin
      if ((mh[u] & ((1 << j) - 1)) == (mpat[u] >> (PW - j)))
        return j;
    end
    return 0;
  endfunction

  function automatic logic m_dout(int u);
    return !midle[u] && mk[u] == PW;
  endfunction

  function automatic logic m_busy(int u);
    return !midle[u];
  endfunction

  function automatic logic [7:0] m_cnt(int u);
    return 8'(mc[u]);
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      midle[u] = 1'b1;
      mh[u]    = 0;
      mn[u]    = 0;
      mk[u]    = 0;
      mc[u]    = 0;
      mpat[u]  = 9;
    end
  endtask

  task automatic model_edge();
    for (int u = 0; u < 3; u++) begin
      if (midle[u]) begin
        midle[u] = 1'b0;
        mk[u]    = 0;
        if (pl) mpat[u] = int'(pi);
      end else if (pl) begin
        mpat[u] = int'(pi);
        mh[u]   = 0;
        mn[u]   = 0;
        mk[u]   = 0;
      end else if (v) begin
        mh[u] = ((mh[u] << 1) | int'(d)) & 16'hffff;
        if (mn[u] < PW) mn[u]++;
        mk[u] = calc_k(u);
        if (mk[u] == PW) begin
          if (mc[u] < cmax(u)) mc[u]++;
          if (!ov(u)) begin
            mh[u] = 0;
            mn[u] = 0;
          end
        end
      end
      if (cc) mc[u] = 0;
    end
  endtask

  task automatic step(input logic iv, input logic id, input logic ipl,
                      input logic [3:0] ipi, input logic icc);
    v  = iv;
    d  = id;
    pl = ipl;
    pi = ipi;
    cc = icc;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #3;
    for (int u = 0; u < 3; u++) begin
      total++;
      if (dout_a[u] !== 1'b0) begin
        bad++;
        $display("FAIL reset_dout u%0d got=%b want=0", u, dout_a[u]);
      end
      total++;
      if (busy_a[u] !== 1'b0) begin
        bad++;
        $display("FAIL reset_busy u%0d got=%b want=0", u, busy_a[u]);
      end
      total++;
      if (cnt_a[u] !== 8'd0) begin
        bad++;
        $display("FAIL reset_cnt u%0d got=%0d want=0", u, cnt_a[u]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    step(1, 1, 0, 4'h0, 0);
    for (int u = 0; u < 3; u++) begin
      total++;
      if (busy_a[u] !== 1'b1 || dout_a[u] !== 1'b0) begin
        bad++;
        $display("FAIL idle_exit u%0d got busy=%b dout=%b want 1/0",
                 u, busy_a[u], dout_a[u]);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] s;
    s = 4'b1001;
    for (int b = 3; b >= 0; b--) begin
      step(1, s[b], 0, 4'h0, 0);
      for (int u = 0; u < 3; u++) begin
        total++;
        if (dout_a[u] !== m_dout(u) || cnt_a[u] !== m_cnt(u)) begin
          bad++;
          $display("FAIL basic u%0d bit%0d got=%b/%0d want=%b/%0d",
                   u, b, dout_a[u], cnt_a[u], m_dout(u), m_cnt(u));
        end
      end
    end
    total++;
    if (dout0 !== 1'b1 || cnt0 !== 8'd1) begin
      bad++;
      $display("FAIL basic_final got=%b/%0d want=1/1", dout0, cnt0);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] s;
    s = 7'b1001001;
    step(0, 0, 1, 4'b1001, 1);
    for (int b = 6; b >= 0; b--) begin
      step(1, s[b], 0, 4'h0, 0);
      for (int u = 0; u < 3; u++) begin
        total++;
        if (dout_a[u] !== m_dout(u) || cnt_a[u] !== m_cnt(u)) begin
          bad++;
          $display("FAIL overlap u%0d bit%0d got=%b/%0d want=%b/%0d",
                   u, b, dout_a[u], cnt_a[u], m_dout(u), m_cnt(u));
        end
      end
    end
    total++;
    if (cnt0 !== 8'd2 || dout0 !== 1'b1) begin
      bad++;
      $display("FAIL overlap_on got=%0d/%b want=2/1", cnt0, dout0);
    end
    total++;
    if (cnt1 !== 8'd1 || dout1 !== 1'b0) begin
      bad++;
      $display("FAIL overlap_off got=%0d/%b want=1/0", cnt1, dout1);
    end
  endtask

  task automatic test_saturate();
    step(0, 0, 1, 4'b1111, 1);
    for (int b = 1; b <= 7; b++) begin
      step(1, 1, 0, 4'h0, 0);
      for (int u = 0; u < 3; u++) begin
        total++;
        if (dout_a[u] !== m_dout(u) || cnt_a[u] !== m_cnt(u)) begin
          bad++;
          $display("FAIL sat u%0d bit%0d got=%b/%0d want=%b/%0d",
                   u, b, dout_a[u], cnt_a[u], m_dout(u), m_cnt(u));
        end
      end
    end
    total++;
    if (cnt2 !== 2'd3 || dout2 !== 1'b1) begin
      bad++;
      $display("FAIL sat_cnt2 got=%0d/%b want=3/1", cnt2, dout2);
    end
    total++;
    if (cnt0 !== 8'd4) begin
      bad++;
      $display("FAIL sat_cnt0 got=%0d want=4", cnt0);
    end
  endtask

  task automatic test_gap_reload();
    logic [3:0] s;
    step(0, 0, 1, 4'b1001, 1);
    step(1, 1, 0, 4'h0, 0);
    step(1, 0, 0, 4'h0, 0);
    for (int g = 0; g < 3; g++) step(0, 1, 0, 4'h0, 0);
    step(1, 0, 0, 4'h0, 0);
    step(1, 1, 0, 4'h0, 0);
    for (int g = 0; g < 3; g++) begin
      step(0, 0, 0, 4'h0, 0);
      total++;
      if (dout0 !== 1'b1 || cnt0 !== 8'd1) begin
        bad++;
        $display("FAIL gap_hold g%0d got=%b/%0d want=1/1", g, dout0, cnt0);
      end
    end
    step(1, 1, 0, 4'h0, 0);
    step(1, 0, 0, 4'h0, 0);
    step(1, 0, 0, 4'h0, 0);
    step(0, 1, 1, 4'b0110, 0);
    for (int u = 0; u < 3; u++) begin
      total++;
      if (dout_a[u] !== 1'b0 || busy_a[u] !== 1'b1) begin
        bad++;
        $display("FAIL reload u%0d got=%b/%b want=0/1",
                 u, dout_a[u], busy_a[u]);
      end
    end
    s = 4'b0110;
    for (int b = 3; b >= 0; b--) step(1, s[b], 0, 4'h0, 0);
    for (int u = 0; u < 3; u++) begin
      total++;
      if (dout_a[u] !== 1'b1 || cnt_a[u] !== m_cnt(u)) begin
        bad++;
        $display("FAIL reload_match u%0d got=%b/%0d want=1/%0d",
                 u, dout_a[u], cnt_a[u], m_cnt(u));
      end
    end
  endtask

  task automatic test_random();
    logic rv, rd, rpl, rcc;
    logic [3:0] rpi;
    for (int n = 0; n < 600; n++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rd  = 1'($urandom_range(0, 1));
      rpl = ($urandom_range(0, 19) == 0);
      rpi = 4'($urandom_range(0, 15));
      rcc = ($urandom_range(0, 29) == 0);
      step(rv, rd, rpl, rpi, rcc);
      for (int u = 0; u < 3; u++) begin
        total++;
        if (dout_a[u] !== m_dout(u) || busy_a[u] !== m_busy(u) ||
            cnt_a[u] !== m_cnt(u)) begin
          bad++;
          $display("FAIL rand n%0d u%0d got=%b/%b/%0d want=%b/%b/%0d",
                   n, u, dout_a[u], busy_a[u], cnt_a[u],
                   m_dout(u), m_busy(u), m_cnt(u));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] s;
    step(0, 0, 1, 4'b0110, 1);
    s = 4'b0110;
    for (int b = 3; b >= 0; b--) step(1, s[b], 0, 4'h0, 0);
    total++;
    if (dout0 !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset dout got=%b want=1", dout0);
    end
    v = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    for (int u = 0; u < 3; u++) begin
      total++;
      if (dout_a[u] !== 1'b0 || busy_a[u] !== 1'b0 || cnt_a[u] !== 8'd0) begin
        bad++;
        $display("FAIL async_rst u%0d got=%b/%b/%0d want=0/0/0",
                 u, dout_a[u], busy_a[u], cnt_a[u]);
      end
    end
    #1;
    rst = 1'b1;
    step(0, 0, 0, 4'h0, 0);
    s = 4'b1001;
    for (int b = 3; b >= 0; b--) step(1, s[b], 0, 4'h0, 0);
    for (int u = 0; u < 3; u++) begin
      total++;
      if (dout_a[u] !== 1'b1 || cnt_a[u] !== 8'd1) begin
        bad++;
        $display("FAIL pat_restore u%0d got=%b/%0d want=1/1",
                 u, dout_a[u], cnt_a[u]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_saturate();
    test_gap_reload();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
